// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the dual-clock FIFO: producer push port, RAM write port,
// pointer exchange with the read domain and status flags.
interface fifo_wr_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 10
);
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             ovf_clr;
  logic [ADDR:0]    rd_ptr_gray;
  logic             ram_wr_en;
  logic [ADDR-1:0]  ram_wr_addr;
  logic [WIDTH-1:0] ram_wr_data;
  logic [ADDR:0]    wr_ptr_gray;
  logic             full;
  logic             almost_full;
  logic [ADDR:0]    wr_level;
  logic             overflow;

  modport master (
    output wr_req, wr_data, ovf_clr, rd_ptr_gray,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, wr_ptr_gray,
    input  full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_req, wr_data, ovf_clr, rd_ptr_gray,
    output ram_wr_en, ram_wr_addr, ram_wr_data, wr_ptr_gray,
    output full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO: push acceptance, RAM write
// port, binary/Gray write pointers, read-pointer synchronizer and fill flags.
module fifo_wr_ctrl #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 10,
  parameter int AF_TH = 2**ADDR - 4
) (
  input  logic          wr_clk,
  input  logic          reset,
  fifo_wr_ctrl_if.slave bus
);

  localparam logic [ADDR:0] AF_LVL = (ADDR+1)'(AF_TH);

  function automatic logic [ADDR:0] bin2gray(input logic [ADDR:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
    logic [ADDR:0] b;
    b[ADDR] = g[ADDR];
    for (int i = ADDR - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR:0] r_bin;
  logic [ADDR:0] r_gray;
  logic [ADDR:0] r_rq1;
  logic [ADDR:0] r_rq2;
  logic [ADDR:0] r_level;
  logic          r_full;
  logic          r_af;
  logic          r_ovf;

  logic          w_push;
  logic [ADDR:0] w_bin_next;
  logic [ADDR:0] w_gray_next;
  logic [ADDR:0] w_level_next;
  logic          w_full_next;
  logic          w_af_next;
  logic          w_ovf_next;

  // Next-state datapath for pointers, flags and the sticky overflow bit.
  always_comb begin
    w_push       = bus.wr_req & ~r_full & ~reset;
    w_bin_next   = r_bin + {{ADDR{1'b0}}, w_push};
    w_gray_next  = bin2gray(w_bin_next);
    w_level_next = w_bin_next - gray2bin(r_rq2);
    // Full when the write pointer is one lap ahead of the synchronized read pointer.
    w_full_next  = (w_gray_next == {~r_rq2[ADDR:ADDR-1], r_rq2[ADDR-2:0]});
    w_af_next    = (w_level_next >= AF_LVL);
    w_ovf_next   = r_ovf;
    if (bus.wr_req & r_full) begin
      w_ovf_next = 1'b1;
    end else if (bus.ovf_clr) begin
      w_ovf_next = 1'b0;
    end else begin
      w_ovf_next = r_ovf;
    end
  end

  // Pointer, synchronizer and status registers.
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_rq1   <= '0;
      r_rq2   <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_rq1   <= bus.rd_ptr_gray;
      r_rq2   <= r_rq1;
      r_level <= w_level_next;
      r_full  <= w_full_next;
      r_af    <= w_af_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign bus.ram_wr_en   = w_push;
  assign bus.ram_wr_addr = r_bin[ADDR-1:0];
  assign bus.ram_wr_data = bus.wr_data;
  assign bus.wr_ptr_gray = r_gray;
  assign bus.full        = r_full;
  assign bus.almost_full = r_af;
  assign bus.wr_level    = r_level;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with an 8-entry FIFO (ADDR=3, AF_TH=6).
module tb_fifo_wr_ctrl;

  logic wr_clk = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fifo_wr_ctrl_if #(.WIDTH(8), .ADDR(3)) bus ();

  fifo_wr_ctrl #(.WIDTH(8), .ADDR(3), .AF_TH(6)) dut (
    .wr_clk (wr_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    bus.wr_req = 1'b1; bus.wr_data = 8'hAA; bus.ovf_clr = 1'b0; bus.rd_ptr_gray = 4'd0;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b exp 0", bus.ram_wr_en); end
    checks++;
    if (bus.wr_ptr_gray !== 4'd0 || bus.wr_level !== 4'd0 || bus.full !== 1'b0 ||
        bus.almost_full !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_outs got gray=%h lvl=%0d full=%b af=%b ovf=%b exp all 0",
               bus.wr_ptr_gray, bus.wr_level, bus.full, bus.almost_full, bus.overflow);
    end
    bus.wr_req = 1'b0;
    #2 reset = 1'b0;
    tick();
    bus.wr_req = 1'b1;
    #1;
    checks++;
    if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 3'd0) begin
      errors++; $display("FAIL rst_first_push got en=%b addr=%0d exp en=1 addr=0", bus.ram_wr_en, bus.ram_wr_addr);
    end
    tick();
    bus.wr_req = 1'b0;
    checks++;
    if (bus.wr_ptr_gray !== 4'd1 || bus.wr_level !== 4'd1) begin
      errors++; $display("FAIL rst_first_ptr got gray=%h lvl=%0d exp 1 1", bus.wr_ptr_gray, bus.wr_level);
    end
    // Asynchronous assertion between edges must clear state without a clock edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.wr_ptr_gray !== 4'd0 || bus.wr_level !== 4'd0) begin
      errors++; $display("FAIL rst_async got gray=%h lvl=%0d exp 0 0", bus.wr_ptr_gray, bus.wr_level);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] n;
    bus.rd_ptr_gray = 4'd0;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = 8'h10 + 8'(i);
      #1;
      checks++;
      if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 3'(i) || bus.ram_wr_data !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL fill_port[%0d] got en=%b addr=%0d data=%h exp en=1 addr=%0d data=%h",
                 i, bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data, i, 8'h10 + 8'(i));
      end
      tick();
      n = 4'(i + 1);
      checks++;
      if (bus.wr_level !== n || bus.wr_ptr_gray !== g4(n) ||
          bus.almost_full !== (n >= 4'd6) || bus.full !== (n == 4'd8)) begin
        errors++;
        $display("FAIL fill_flags[%0d] got lvl=%0d gray=%h af=%b full=%b exp lvl=%0d gray=%h af=%b full=%b",
                 i, bus.wr_level, bus.wr_ptr_gray, bus.almost_full, bus.full,
                 n, g4(n), (n >= 4'd6), (n == 4'd8));
      end
    end
    bus.wr_req = 1'b0;
  endtask

  task automatic test_overflow();
    bus.wr_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.ram_wr_en !== 1'b0) begin errors++; $display("FAIL ovf_wr_en[%0d] got %b exp 0", i, bus.ram_wr_en); end
      tick();
      checks++;
      if (bus.wr_ptr_gray !== 4'b1100 || bus.wr_level !== 4'd8 || bus.overflow !== 1'b1) begin
        errors++;
        $display("FAIL ovf_hold[%0d] got gray=%h lvl=%0d ovf=%b exp c 8 1", i, bus.wr_ptr_gray, bus.wr_level, bus.overflow);
      end
    end
    bus.wr_req = 1'b0;
    tick();
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
    bus.ovf_clr = 1'b1; bus.wr_req = 1'b1;
    tick();
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", bus.overflow); end
    bus.wr_req = 1'b0;
    tick();
    bus.ovf_clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
  endtask

  task automatic test_drain();
    bus.rd_ptr_gray = 4'b0010;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (e < 3 && (bus.full !== 1'b1 || bus.wr_level !== 4'd8)) begin
        errors++; $display("FAIL drain_early[%0d] got full=%b lvl=%0d exp 1 8", e, bus.full, bus.wr_level);
      end else if (e == 3 && (bus.full !== 1'b0 || bus.wr_level !== 4'd5 || bus.almost_full !== 1'b0)) begin
        errors++; $display("FAIL drain_edge3 got full=%b lvl=%0d af=%b exp 0 5 0", bus.full, bus.wr_level, bus.almost_full);
      end
    end
    bus.wr_req = 1'b1; bus.wr_data = 8'h55;
    #1;
    checks++;
    if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 3'd0) begin
      errors++; $display("FAIL drain_wrap_addr got en=%b addr=%0d exp 1 0", bus.ram_wr_en, bus.ram_wr_addr);
    end
    tick();
    bus.wr_req = 1'b0;
    checks++;
    if (bus.wr_level !== 4'd6 || bus.almost_full !== 1'b1 || bus.wr_ptr_gray !== 4'b1101) begin
      errors++; $display("FAIL drain_push got lvl=%0d af=%b gray=%h exp 6 1 d", bus.wr_level, bus.almost_full, bus.wr_ptr_gray);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    logic [3:0] exp_lvl;
    reset = 1'b1; bus.wr_req = 1'b0; bus.rd_ptr_gray = 4'd0;
    #3 reset = 1'b0;
    prev = 4'd0;
    bus.wr_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_lvl = (k < 5) ? 4'(k) : 4'd5;
      checks++;
      if ($countones(prev ^ bus.wr_ptr_gray) != 1 || bus.wr_ptr_gray[3] !== 1'((k / 8) % 2) ||
          bus.full !== 1'b0 || bus.wr_level !== exp_lvl) begin
        errors++;
        $display("FAIL wrap[%0d] got gray=%h prev=%h full=%b lvl=%0d exp one-bit step msb=%0d full=0 lvl=%0d",
                 k, bus.wr_ptr_gray, prev, bus.full, bus.wr_level, (k / 8) % 2, exp_lvl);
      end
      prev = bus.wr_ptr_gray;
      bus.rd_ptr_gray = g4(4'((k >= 2) ? k - 2 : 0));
    end
    bus.wr_req = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    reset = 1'b1; bus.rd_ptr_gray = 4'd0;
    #3 reset = 1'b0;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.wr_req = 1'b0;
    checks++;
    if (bus.wr_level !== 4'd5) begin errors++; $display("FAIL mid_pre got lvl=%0d exp 5", bus.wr_level); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.wr_level !== 4'd0 || bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.wr_ptr_gray !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset got lvl=%0d full=%b af=%b gray=%h exp 0 0 0 0",
               bus.wr_level, bus.full, bus.almost_full, bus.wr_ptr_gray);
    end
    #1 reset = 1'b0;
    bus.wr_req = 1'b1;
    #1;
    checks++;
    if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 3'd0) begin
      errors++; $display("FAIL mid_next_addr got en=%b addr=%0d exp 1 0", bus.ram_wr_en, bus.ram_wr_addr);
    end
    tick();
    bus.wr_req = 1'b0;
    checks++;
    if (bus.wr_ptr_gray !== 4'd1) begin errors++; $display("FAIL mid_next_ptr got %h exp 1", bus.wr_ptr_gray); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
